// File: rtl/pipe_hazard_unit_if.sv
// Hazard-unit port bundle: ID-stage instruction fields and pipeline events in,
// pipeline-register gating, forwarding selects and interrupt handshake out.
interface pipe_hazard_unit_if #(
    parameter int unsigned RADDR_W = 3,
    parameter int unsigned CNT_W   = 16
);
    // ID-stage instruction description
    logic               id_valid;
    logic [RADDR_W-1:0] id_rs;
    logic [RADDR_W-1:0] id_rd;
    logic               id_uses_rs;
    logic               id_uses_rd;
    logic               id_writes;
    logic               id_is_load;

    // Pipeline events
    logic               br_taken;
    logic               int_req;

    // Pipeline control
    logic               stall_fd;
    logic               bubble_de;
    logic               flush_fd;
    logic [1:0]         fwd_a;
    logic [1:0]         fwd_b;
    logic               int_ack;
    logic [CNT_W-1:0]   stall_cnt;

    // Control-unit side
    modport master (
        output id_valid, id_rs, id_rd, id_uses_rs, id_uses_rd, id_writes, id_is_load,
        output br_taken, int_req,
        input  stall_fd, bubble_de, flush_fd, fwd_a, fwd_b, int_ack, stall_cnt
    );

    // Hazard-unit side
    modport slave (
        input  id_valid, id_rs, id_rd, id_uses_rs, id_uses_rd, id_writes, id_is_load,
        input  br_taken, int_req,
        output stall_fd, bubble_de, flush_fd, fwd_a, fwd_b, int_ack, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller for the 5-stage pipeline. Shadows the EX/MEM/WB
// instruction slots, selects ALU operand bypass sources, inserts load-use bubbles,
// flushes the front end on taken branches and empties the pipe before an interrupt.
module pipe_hazard_unit #(
    parameter int unsigned RADDR_W  = 3,
    parameter int unsigned LOAD_LAT = 1,   // 1..3 stall cycles per load-use hazard
    parameter int unsigned CNT_W    = 16
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_unit_if.slave bus
);

    typedef struct packed {
        logic               valid;
        logic [RADDR_W-1:0] rd;
        logic               writes;
        logic               is_load;
        logic [RADDR_W-1:0] rs;
        logic               uses_rs;
        logic               uses_rd;
    } slot_t;

    typedef enum logic [1:0] {
        StRun,
        StStall,
        StDrain
    } state_e;

    localparam int unsigned      WaitW      = 2;
    localparam logic [WaitW-1:0] WaitInit   = WaitW'(LOAD_LAT - 1);
    localparam bit               MultiCycle = (LOAD_LAT > 1);

    localparam logic [1:0] FwdRf  = 2'b00;
    localparam logic [1:0] FwdMem = 2'b01;
    localparam logic [1:0] FwdWb  = 2'b10;

    slot_t            ex_q, mem_q, wb_q;
    slot_t            ex_d;
    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q;

    logic             load_use;
    logic             pipe_empty;
    logic             stall_fd;
    logic             bubble_de;
    logic             flush_fd;
    logic             int_ack;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;

    // Operand-source fields of the older slots are kept for tracing only.
    logic unused_slot_fields;
    assign unused_slot_fields = ^{mem_q.rs, mem_q.uses_rs, mem_q.uses_rd,
                                  wb_q.rs, wb_q.uses_rs, wb_q.uses_rd, wb_q.is_load};

    // Bypass source for one EX operand; a load in MEM has no data yet, so it never forwards.
    function automatic logic [1:0] fwd_sel(input slot_t              mem,
                                           input slot_t              wb,
                                           input logic [RADDR_W-1:0] src,
                                           input logic               uses);
        logic [1:0] sel;
        sel = FwdRf;
        if (uses) begin
            if (mem.valid && mem.writes && !mem.is_load && (mem.rd == src)) begin
                sel = FwdMem;
            end else if (wb.valid && wb.writes && (wb.rd == src)) begin
                sel = FwdWb;
            end
        end
        return sel;
    endfunction

    // Forwarding selects for the instruction currently in EX.
    always_comb begin
        fwd_a = fwd_sel(mem_q, wb_q, ex_q.rs, ex_q.uses_rs);
        fwd_b = fwd_sel(mem_q, wb_q, ex_q.rd, ex_q.uses_rd);
    end

    // Hazard and pipe-occupancy conditions.
    always_comb begin
        load_use = bus.id_valid && ex_q.valid && ex_q.is_load && ex_q.writes &&
                   ((bus.id_uses_rs && (bus.id_rs == ex_q.rd)) ||
                    (bus.id_uses_rd && (bus.id_rd == ex_q.rd)));
        pipe_empty = !ex_q.valid && !mem_q.valid && !wb_q.valid;
    end

    // Control FSM: next state and pipeline gating; a taken branch overrides everything.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        stall_fd  = 1'b0;
        bubble_de = 1'b0;
        flush_fd  = 1'b0;
        int_ack   = 1'b0;

        if (bus.br_taken) begin
            flush_fd  = 1'b1;
            bubble_de = 1'b1;
            // The stalled ID instruction is wrong-path; a pending drain still has to finish.
            if (state_q == StStall) begin
                state_d = StRun;
            end
        end else begin
            unique case (state_q)
                StRun: begin
                    if (bus.int_req) begin
                        stall_fd  = 1'b1;
                        bubble_de = 1'b1;
                        state_d   = StDrain;
                    end else if (load_use) begin
                        stall_fd  = 1'b1;
                        bubble_de = 1'b1;
                        if (MultiCycle) begin
                            wait_d  = WaitInit;
                            state_d = StStall;
                        end
                    end
                end
                StStall: begin
                    stall_fd  = 1'b1;
                    bubble_de = 1'b1;
                    wait_d    = wait_q - WaitW'(1);
                    if (wait_q <= WaitW'(1)) begin
                        state_d = StRun;
                    end
                end
                StDrain: begin
                    if (pipe_empty) begin
                        int_ack = 1'b1;
                        state_d = StRun;
                    end else begin
                        stall_fd  = 1'b1;
                        bubble_de = 1'b1;
                    end
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end
    end

    // FSM state and load-use wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next EX slot: the ID instruction unless a bubble is injected.
    always_comb begin
        ex_d = '0;
        if (bus.id_valid && !bubble_de) begin
            ex_d.valid   = 1'b1;
            ex_d.rd      = bus.id_rd;
            ex_d.writes  = bus.id_writes;
            ex_d.is_load = bus.id_is_load;
            ex_d.rs      = bus.id_rs;
            ex_d.uses_rs = bus.id_uses_rs;
            ex_d.uses_rd = bus.id_uses_rd;
        end
    end

    // In-flight instruction tracker advancing EX -> MEM -> WB every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    // Saturating count of cycles in which a bubble entered ID/EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (bubble_de && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall_fd  = stall_fd;
    assign bus.bubble_de = bubble_de;
    assign bus.flush_fd  = flush_fd;
    assign bus.fwd_a     = fwd_a;
    assign bus.fwd_b     = fwd_b;
    assign bus.int_ack   = int_ack;
    assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: two instances (LOAD_LAT 1 and 3) share one stimulus
// stream; directed table, hand sequences and a random run against a reference model.
module tb_pipe_hazard_unit;

    localparam int unsigned CW1   = 6;
    localparam int unsigned CW3   = 16;
    localparam int          CMAX1 = (1 << CW1) - 1;
    localparam int          CMAX3 = (1 << CW3) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_unit_if #(.RADDR_W(3), .CNT_W(CW1)) if1 ();
    pipe_hazard_unit_if #(.RADDR_W(3), .CNT_W(CW3)) if3 ();

    pipe_hazard_unit #(.RADDR_W(3), .LOAD_LAT(1), .CNT_W(CW1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    pipe_hazard_unit #(.RADDR_W(3), .LOAD_LAT(3), .CNT_W(CW3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3)
    );

    typedef struct {
        logic       v;
        logic [2:0] rs;
        logic [2:0] rd;
        logic       urs, urd, wr, ld, br, irq;
    } in_t;

    typedef struct {
        logic       stall, bub, flush;
        logic [1:0] fa, fb;
        logic       ack;
        int         cnt;
    } out_t;

    typedef struct {
        in_t  in;
        out_t exp;
    } vec_t;

    typedef struct {
        logic       v;
        logic [2:0] rd, rs;
        logic       wr, ld, urs, urd;
    } slot_t;

    typedef struct {
        slot_t ex, mem, wb;
        int    stall_left;
        bit    draining;
        int    cnt;
    } model_t;

    int     checks = 0;
    int     errors = 0;
    model_t m1, m3;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cmp_out(input string tag, input out_t g, input out_t e);
        check({tag, ".stall_fd"}, 32'(g.stall), 32'(e.stall));
        check({tag, ".bubble_de"}, 32'(g.bub), 32'(e.bub));
        check({tag, ".flush_fd"}, 32'(g.flush), 32'(e.flush));
        check({tag, ".fwd_a"}, 32'(g.fa), 32'(e.fa));
        check({tag, ".fwd_b"}, 32'(g.fb), 32'(e.fb));
        check({tag, ".int_ack"}, 32'(g.ack), 32'(e.ack));
        check({tag, ".stall_cnt"}, 32'(g.cnt), 32'(e.cnt));
    endtask

    function automatic in_t ins(logic v, logic [2:0] rs, logic [2:0] rd,
                                logic urs, logic urd, logic wr, logic ld);
        in_t i;
        i.v = v; i.rs = rs; i.rd = rd; i.urs = urs; i.urd = urd;
        i.wr = wr; i.ld = ld; i.br = 1'b0; i.irq = 1'b0;
        return i;
    endfunction

    function automatic out_t outs(logic st, logic bu, logic fl, logic [1:0] fa,
                                  logic [1:0] fb, logic ak, int cnt);
        out_t o;
        o.stall = st; o.bub = bu; o.flush = fl; o.fa = fa; o.fb = fb; o.ack = ak; o.cnt = cnt;
        return o;
    endfunction

    function automatic slot_t empty_slot();
        slot_t s;
        s.v = 0; s.rd = 0; s.rs = 0; s.wr = 0; s.ld = 0; s.urs = 0; s.urd = 0;
        return s;
    endfunction

    function automatic model_t model_reset();
        model_t m;
        m.ex = empty_slot(); m.mem = empty_slot(); m.wb = empty_slot();
        m.stall_left = 0; m.draining = 0; m.cnt = 0;
        return m;
    endfunction

    // Youngest older producer of register r, skipping a load still in MEM.
    function automatic logic [1:0] src_of(model_t m, logic [2:0] r, logic uses);
        if (!uses) return 2'd0;
        if (m.mem.v && m.mem.wr && !m.mem.ld && m.mem.rd == r) return 2'd1;
        if (m.wb.v && m.wb.wr && m.wb.rd == r) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_eval(input model_t m, input in_t i, input int lat, input int cmax,
                              output out_t o, output model_t n);
        bit haz;
        n = m;
        o = outs(0, 0, 0, src_of(m, m.ex.rs, m.ex.urs), src_of(m, m.ex.rd, m.ex.urd), 0, m.cnt);
        haz = i.v && m.ex.v && m.ex.ld && m.ex.wr &&
              ((i.urs && i.rs == m.ex.rd) || (i.urd && i.rd == m.ex.rd));
        if (i.br) begin
            o.flush = 1; o.bub = 1; n.stall_left = 0;
        end else if (m.draining) begin
            if (!m.ex.v && !m.mem.v && !m.wb.v) begin
                o.ack = 1; n.draining = 0;
            end else begin
                o.stall = 1; o.bub = 1;
            end
        end else if (m.stall_left > 0) begin
            o.stall = 1; o.bub = 1; n.stall_left = m.stall_left - 1;
        end else if (i.irq) begin
            o.stall = 1; o.bub = 1; n.draining = 1;
        end else if (haz) begin
            o.stall = 1; o.bub = 1; n.stall_left = lat - 1;
        end
        if (o.bub && m.cnt < cmax) n.cnt = m.cnt + 1;
        n.wb  = m.mem;
        n.mem = m.ex;
        n.ex  = empty_slot();
        if (i.v && !o.bub) begin
            n.ex.v = 1; n.ex.rd = i.rd; n.ex.rs = i.rs; n.ex.wr = i.wr;
            n.ex.ld = i.ld; n.ex.urs = i.urs; n.ex.urd = i.urd;
        end
    endtask

    task automatic drive(input in_t i);
        if1.id_valid = i.v;   if3.id_valid = i.v;
        if1.id_rs = i.rs;     if3.id_rs = i.rs;
        if1.id_rd = i.rd;     if3.id_rd = i.rd;
        if1.id_uses_rs = i.urs; if3.id_uses_rs = i.urs;
        if1.id_uses_rd = i.urd; if3.id_uses_rd = i.urd;
        if1.id_writes = i.wr; if3.id_writes = i.wr;
        if1.id_is_load = i.ld; if3.id_is_load = i.ld;
        if1.br_taken = i.br;  if3.br_taken = i.br;
        if1.int_req = i.irq;  if3.int_req = i.irq;
    endtask

    // Apply inputs, sample outputs at the falling edge, then advance one clock.
    task automatic run_cycle(input in_t i, output out_t o1, output out_t o3);
        drive(i);
        @(negedge clk);
        o1 = outs(if1.stall_fd, if1.bubble_de, if1.flush_fd, if1.fwd_a, if1.fwd_b,
                  if1.int_ack, int'(if1.stall_cnt));
        o3 = outs(if3.stall_fd, if3.bubble_de, if3.flush_fd, if3.fwd_a, if3.fwd_b,
                  if3.int_ack, int'(if3.stall_cnt));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(ins(0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        m1 = model_reset();
        m3 = model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t   tbl[16];
        in_t    i, idle, ld3, use3;
        out_t   g1, g3, e1, e3;
        model_t n1, n3;

        idle = ins(0, 0, 0, 0, 0, 0, 0);
        ld3  = ins(1, 0, 3, 0, 0, 1, 1);
        use3 = ins(1, 3, 6, 1, 0, 1, 0);

        // Forwarding and single-cycle load-use, LOAD_LAT=1 instance.
        tbl[0]  = '{ins(1, 0, 1, 0, 0, 1, 0), outs(0, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{ins(1, 1, 4, 1, 0, 1, 0), outs(0, 0, 0, 0, 0, 0, 0)};
        tbl[2]  = '{idle,                     outs(0, 0, 0, 1, 0, 0, 0)};
        tbl[3]  = '{ins(1, 0, 5, 0, 0, 1, 0), outs(0, 0, 0, 0, 0, 0, 0)};
        tbl[4]  = '{idle,                     outs(0, 0, 0, 0, 0, 0, 0)};
        tbl[5]  = '{ins(1, 5, 6, 1, 0, 1, 0), outs(0, 0, 0, 0, 0, 0, 0)};
        tbl[6]  = '{idle,                     outs(0, 0, 0, 2, 0, 0, 0)};
        tbl[7]  = '{ins(1, 0, 2, 0, 0, 1, 0), outs(0, 0, 0, 0, 0, 0, 0)};
        tbl[8]  = '{ins(1, 0, 2, 0, 0, 1, 0), outs(0, 0, 0, 0, 0, 0, 0)};
        tbl[9]  = '{ins(1, 0, 2, 0, 1, 0, 0), outs(0, 0, 0, 0, 0, 0, 0)};
        tbl[10] = '{idle,                     outs(0, 0, 0, 0, 1, 0, 0)};
        tbl[11] = '{ld3,                      outs(0, 0, 0, 0, 0, 0, 0)};
        tbl[12] = '{use3,                     outs(1, 1, 0, 0, 0, 0, 0)};
        tbl[13] = '{use3,                     outs(0, 0, 0, 0, 0, 0, 1)};
        tbl[14] = '{idle,                     outs(0, 0, 0, 2, 0, 0, 1)};
        tbl[15] = '{idle,                     outs(0, 0, 0, 0, 0, 0, 1)};

        do_reset();

        // Reset state of both instances.
        run_cycle(idle, g1, g3);
        cmp_out("reset1", g1, outs(0, 0, 0, 0, 0, 0, 0));
        cmp_out("reset3", g3, outs(0, 0, 0, 0, 0, 0, 0));

        do_reset();
        for (int k = 0; k < 16; k++) begin
            run_cycle(tbl[k].in, g1, g3);
            cmp_out($sformatf("tbl%0d", k), g1, tbl[k].exp);
        end

        // LOAD_LAT=3: three stall cycles, then the consumer proceeds.
        do_reset();
        run_cycle(ld3, g1, g3);
        check("lat3.first", 32'(g3.stall), 0);
        for (int k = 0; k < 3; k++) begin
            run_cycle(use3, g1, g3);
            check($sformatf("lat3.stall%0d", k), 32'({g3.stall, g3.bub}), 32'b11);
        end
        run_cycle(use3, g1, g3);
        check("lat3.release", 32'(g3.stall), 0);
        check("lat3.cnt", 32'(g3.cnt), 3);

        // Taken branch while stalled aborts the stall.
        do_reset();
        run_cycle(ld3, g1, g3);
        run_cycle(use3, g1, g3);
        check("brst.stall", 32'(g3.stall), 1);
        i = use3; i.br = 1'b1;
        run_cycle(i, g1, g3);
        check("brst.flush", 32'({g3.flush, g3.bub, g3.stall}), 32'b110);
        run_cycle(use3, g1, g3);
        check("brst.run", 32'({g3.flush, g3.bub, g3.stall}), 32'b000);
        check("brst.cnt", 32'(g3.cnt), 2);

        // Interrupt drain with three occupied slots; int_req drops mid-drain.
        do_reset();
        run_cycle(ins(1, 0, 1, 0, 0, 1, 0), g1, g3);
        run_cycle(ins(1, 0, 2, 0, 0, 1, 0), g1, g3);
        run_cycle(ins(1, 0, 3, 0, 0, 1, 0), g1, g3);
        for (int k = 0; k < 5; k++) begin
            i = ins(1, 0, 4, 0, 0, 1, 0);
            i.irq = (k == 0);
            run_cycle(i, g1, g3);
            check($sformatf("drain1.stall%0d", k), 32'(g1.stall), (k < 3) ? 1 : 0);
            check($sformatf("drain1.ack%0d", k), 32'(g1.ack), (k == 3) ? 1 : 0);
            check($sformatf("drain3.ack%0d", k), 32'(g3.ack), (k == 3) ? 1 : 0);
        end

        // Reset while draining: clean RUN state and no acknowledge.
        do_reset();
        run_cycle(ins(1, 0, 1, 0, 0, 1, 0), g1, g3);
        i = idle; i.irq = 1'b1;
        run_cycle(i, g1, g3);
        run_cycle(idle, g1, g3);
        check("rstdr.pre", 32'(g1.stall), 1);
        do_reset();
        run_cycle(idle, g1, g3);
        cmp_out("rstdr1", g1, outs(0, 0, 0, 0, 0, 0, 0));
        run_cycle(idle, g1, g3);
        check("rstdr.noack", 32'(g1.ack), 0);

        // Saturation: 2**CW1+5 branch bubbles.
        do_reset();
        i = idle; i.br = 1'b1;
        for (int k = 0; k < 62; k++) run_cycle(i, g1, g3);
        run_cycle(i, g1, g3);
        check("sat.pre", 32'(g1.cnt), 62);
        for (int k = 0; k < 6; k++) run_cycle(i, g1, g3);
        run_cycle(idle, g1, g3);
        check("sat.cnt1", 32'(g1.cnt), 32'(CMAX1));
        check("sat.cnt3", 32'(g3.cnt), 69);

        // Random stimulus against the reference model.
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            i.v   = ($urandom_range(0, 9) < 8);
            i.rs  = 3'($urandom_range(0, 3));
            i.rd  = 3'($urandom_range(0, 3));
            i.urs = 1'($urandom_range(0, 1));
            i.urd = 1'($urandom_range(0, 1));
            i.wr  = ($urandom_range(0, 3) != 0);
            i.ld  = ($urandom_range(0, 2) == 0);
            i.br  = ($urandom_range(0, 9) == 0);
            i.irq = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                drive(i);
                @(posedge clk);
                #1;
                rst = 1'b0;
                m1 = model_reset();
                m3 = model_reset();
            end else begin
                model_eval(m1, i, 1, CMAX1, e1, n1);
                model_eval(m3, i, 3, CMAX3, e3, n3);
                run_cycle(i, g1, g3);
                cmp_out($sformatf("rnd1.%0d", k), g1, e1);
                cmp_out($sformatf("rnd3.%0d", k), g3, e3);
                m1 = n1;
                m3 = n3;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
